// File: rtl/dff_bank_pipe.sv
// Parametrised WIDTH x DEPTH flop bank with valid flag, selectable capture edge and sync set/clear.
// Optional scan chain through all stage bits when DFF_BANK_SCAN_EN is defined.
module dff_bank_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter int unsigned      NEG_CLK = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic             SET,
`ifdef DFF_BANK_SCAN_EN
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
`endif
    input  logic [WIDTH-1:0] D,
    input  logic             D_VLD,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             Q_VLD
);

    // Stage k occupies bits [k*WIDTH +: WIDTH]; this is also the scan order.
    localparam int unsigned CHAIN = WIDTH * DEPTH;

    logic [CHAIN-1:0] stg_q, stg_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             se_c;
    logic             si_c;

`ifdef DFF_BANK_SCAN_EN
    assign se_c = SE;
    assign si_c = SI;
    assign SO   = stg_q[CHAIN-1];
`else
    assign se_c = 1'b0;
    assign si_c = 1'b0;
`endif

    // Ternaries keep X on a control input propagating into the captured state.
    always_comb begin
        stg_d = stg_q;
        vld_d = vld_q;
        stg_d = CLR  ? {DEPTH{RST_VAL}} :
                SET  ? {DEPTH{SET_VAL}} :
                se_c ? CHAIN'({stg_q, si_c}) :
                EN   ? CHAIN'({stg_q, D}) :
                       stg_q;
        vld_d = CLR  ? {DEPTH{1'b0}} :
                SET  ? {DEPTH{1'b0}} :
                se_c ? vld_q :
                EN   ? DEPTH'({vld_q, D_VLD}) :
                       vld_q;
    end

    if (NEG_CLK != 0) begin : g_neg
        always_ff @(negedge CLK or posedge RST) begin
            if (RST) begin
                stg_q <= {DEPTH{RST_VAL}};
                vld_q <= {DEPTH{1'b0}};
            end else begin
                stg_q <= stg_d;
                vld_q <= vld_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                stg_q <= {DEPTH{RST_VAL}};
                vld_q <= {DEPTH{1'b0}};
            end else begin
                stg_q <= stg_d;
                vld_q <= vld_d;
            end
        end
    end

    assign Q     = stg_q[CHAIN-1 -: WIDTH];
    assign QN    = ~stg_q[CHAIN-1 -: WIDTH];
    assign Q_VLD = vld_q[DEPTH-1];

endmodule

// File: tb/tb_dff_bank_pipe.sv
// Directed bench for dff_bank_pipe: four instances share stimulus, each covering one configuration.
// The scan instance and its checks exist only when DFF_BANK_SCAN_EN is defined.
module tb_dff_bank_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       set;
    logic [7:0] d;
    logic       d_vld;
    logic       se;
    logic       si;

    logic [7:0] a_q, a_qn, b_q, b_qn, c_q, c_qn;
    logic       a_vld, b_vld, c_vld;
    logic [3:0] s_q, s_qn;
    logic       s_vld;

    int n_checks = 0;
    int n_fail   = 0;

    // Default configuration: WIDTH=8, DEPTH=2, falling-edge capture
    dff_bank_pipe #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h00), .SET_VAL(8'hFF), .NEG_CLK(1)) u_a (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .SET(set),
`ifdef DFF_BANK_SCAN_EN
        .SE(1'b0), .SI(1'b0), .SO(),
`endif
        .D(d), .D_VLD(d_vld), .Q(a_q), .QN(a_qn), .Q_VLD(a_vld)
    );

    dff_bank_pipe #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h5A), .SET_VAL(8'hFF), .NEG_CLK(1)) u_b (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .SET(set),
`ifdef DFF_BANK_SCAN_EN
        .SE(1'b0), .SI(1'b0), .SO(),
`endif
        .D(d), .D_VLD(d_vld), .Q(b_q), .QN(b_qn), .Q_VLD(b_vld)
    );

    dff_bank_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .SET_VAL(8'hFF), .NEG_CLK(0)) u_c (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .SET(set),
`ifdef DFF_BANK_SCAN_EN
        .SE(1'b0), .SI(1'b0), .SO(),
`endif
        .D(d), .D_VLD(d_vld), .Q(c_q), .QN(c_qn), .Q_VLD(c_vld)
    );

`ifdef DFF_BANK_SCAN_EN
    logic s_so;
    dff_bank_pipe #(.WIDTH(4), .DEPTH(2), .RST_VAL(4'h0), .SET_VAL(4'hF), .NEG_CLK(1)) u_s (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .SET(set),
        .SE(se), .SI(si), .SO(s_so),
        .D(d[3:0]), .D_VLD(d_vld), .Q(s_q), .QN(s_qn), .Q_VLD(s_vld)
    );
`else
    assign s_q   = 4'h0;
    assign s_qn  = 4'hF;
    assign s_vld = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] scan_bits;

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; set = 1'b0;
        d = 8'h00; d_vld = 1'b0; se = 1'b0; si = 1'b0;
        scan_bits = 8'b1011_0010;

        // Power-on reset
        #2 rst = 1'b1;
        #6;
        check("rst_a_q",   32'(a_q),   32'h00);
        check("rst_a_qn",  32'(a_qn),  32'hFF);
        check("rst_a_vld", 32'(a_vld), 32'h0);
        check("rst_b_q",   32'(b_q),   32'h5A);
        check("rst_b_qn",  32'(b_qn),  32'hA5);
        check("rst_c_q",   32'(c_q),   32'h00);
        fall();
        #1 rst = 1'b0;

        // 1: async reset mid-cycle with a full pipeline
        en = 1'b1; d = 8'hA5; d_vld = 1'b1;
        fall();
        fall();
        check("full_q",   32'(a_q),   32'hA5);
        check("full_vld", 32'(a_vld), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async_q",   32'(a_q),   32'h00);
        check("async_qn",  32'(a_qn),  32'hFF);
        check("async_vld", 32'(a_vld), 32'h0);
        #1 rst = 1'b0;

        // 2: single item latency, no change on rising edges
        en = 1'b1; d = 8'h3C; d_vld = 1'b1;
        fall();
        d = 8'h00; d_vld = 1'b0;
        check("lat_n_q",    32'(a_q),   32'h00);
        check("lat_n_vld",  32'(a_vld), 32'h0);
        rise();
        check("lat_r1_q",   32'(a_q),   32'h00);
        fall();
        check("lat_n1_q",   32'(a_q),   32'h3C);
        check("lat_n1_vld", 32'(a_vld), 32'h1);
        rise();
        check("lat_r2_q",   32'(a_q),   32'h3C);
        fall();
        check("lat_n2_q",   32'(a_q),   32'h00);
        check("lat_n2_vld", 32'(a_vld), 32'h0);

        // 3: stall holds contents
        d = 8'h11; d_vld = 1'b1;
        fall();
        d = 8'h22;
        fall();
        check("pre_stall_q", 32'(a_q), 32'h11);
        en = 1'b0; d = 8'h99;
        for (int i = 0; i < 3; i++) begin
            fall();
            check($sformatf("stall%0d_q", i), 32'(a_q), 32'h11);
        end
        en = 1'b1;
        fall();
        check("resume_q",   32'(a_q),   32'h22);
        check("resume_vld", 32'(a_vld), 32'h1);

        // 4: CLR beats SET, then SET alone
        clr = 1'b1; set = 1'b1;
        fall();
        check("clrset_b_q",   32'(b_q),   32'h5A);
        check("clrset_b_qn",  32'(b_qn),  32'hA5);
        check("clrset_b_vld", 32'(b_vld), 32'h0);
        clr = 1'b0;
        fall();
        check("set_b_q",   32'(b_q),   32'hFF);
        check("set_b_vld", 32'(b_vld), 32'h0);
        check("set_a_q",   32'(a_q),   32'hFF);
        set = 1'b0;

        // 5: rising-edge, DEPTH=3 instance
        clr = 1'b1;
        rise();
        clr = 1'b0;
        en = 1'b1; d = 8'h81; d_vld = 1'b1;
        rise();
        d = 8'h00; d_vld = 1'b0;
        check("pos_r1_q", 32'(c_q), 32'h00);
        fall();
        check("pos_f1_q", 32'(c_q), 32'h00);
        rise();
        check("pos_r2_q", 32'(c_q), 32'h00);
        fall();
        rise();
        check("pos_r3_q",   32'(c_q),   32'h81);
        check("pos_r3_vld", 32'(c_vld), 32'h1);
        fall();
        check("pos_f3_q",   32'(c_q),   32'h81);
        rise();
        check("pos_r4_q",   32'(c_q),   32'h00);

`ifdef DFF_BANK_SCAN_EN
        // 6: scan shift of 8 bits through a 4x2 chain with valids held
        fall();
        clr = 1'b1;
        fall();
        clr = 1'b0; en = 1'b1; d = 8'h00; d_vld = 1'b1;
        fall();
        fall();
        check("scan_pre_vld", 32'(s_vld), 32'h1);
        se = 1'b1;
        for (int i = 0; i < 8; i++) begin
            si = scan_bits[7-i];
            fall();
            check($sformatf("scan_so%0d", i + 1), 32'(s_so), (i == 7) ? 32'h1 : 32'h0);
        end
        check("scan_vld", 32'(s_vld), 32'h1);
        check("scan_q",   32'(s_q),   32'hB);
        check("scan_qn",  32'(s_qn),  32'h4);
        se = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
